// File: rtl/pwm_mix_pkg.sv
// Shared constants, FSM encoding and sample-format helpers for the PWM mixer/scheduler.
// PWM_MIX_SCHED_VOLUME_EN adds the master-volume scaling state.
package pwm_mix_pkg;

  localparam int unsigned DW        = 16;
  localparam int unsigned ACC_MAX_W = DW + 4;
  localparam logic [DW-1:0] MIDSCALE = 16'h8000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_MIX,
`ifdef PWM_MIX_SCHED_VOLUME_EN
    S_SCALE,
`endif
    S_LOAD
  } state_e;

  // Clamp a widened signed sum into the signed DW range.
  function automatic logic signed [DW-1:0] sat_to_dw(input logic signed [ACC_MAX_W-1:0] a);
    logic signed [ACC_MAX_W-1:0] hi;
    logic signed [ACC_MAX_W-1:0] lo;
    hi = {{(ACC_MAX_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    lo = {{(ACC_MAX_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    if (a > hi)      return {1'b0, {(DW-1){1'b1}}};
    else if (a < lo) return {1'b1, {(DW-1){1'b0}}};
    else             return a[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] to_offset_bin(input logic signed [DW-1:0] s);
    return {~s[DW-1], s[DW-2:0]};
  endfunction

endpackage

// File: rtl/pwm_mix_sched_sample_tick_gen.sv
// Sample-period counter: one-cycle tick when the count reaches SAMPLE_DIV-1.
// Counting stalls (count held) while enable is low.
module sample_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 2048
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic sample_tick
);

  localparam int unsigned CW = $clog2(SAMPLE_DIV);

  logic [CW-1:0] count_q, count_d;
  logic          tick_q, tick_d;

  always_comb begin
    count_d = count_q;
    if (enable) count_d = (count_q == CW'(SAMPLE_DIV-1)) ? '0 : count_q + CW'(1);
    // Registered tick lands in the cycle the count sits at SAMPLE_DIV-1.
    tick_d = enable && (count_q == CW'(SAMPLE_DIV-2));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign sample_tick = tick_q;

endmodule

// File: rtl/pwm_mix_sched.sv
// Per-sample round-robin voice collector, saturating mixer and pwm_reg writer.
// Optional master volume via PWM_MIX_SCHED_VOLUME_EN (adds master_vol port and one cycle).
module pwm_mix_sched
  import pwm_mix_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned SAMPLE_DIV = 2048
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_VOICES-1:0]    voice_req,
  input  logic [NUM_VOICES*DW-1:0] voice_data,
  output logic [NUM_VOICES-1:0]    voice_ack,
  input  logic                     clear_underrun,
`ifdef PWM_MIX_SCHED_VOLUME_EN
  input  logic [7:0]               master_vol,
`endif
  output logic [DW-1:0]            pwm_reg,
  output logic                     pwm_load,
  output logic                     sample_tick,
  output logic [NUM_VOICES-1:0]    underrun
);

  localparam int unsigned IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned AW = DW + $clog2(NUM_VOICES);

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [NUM_VOICES-1:0]   und_q, und_d;
  logic [DW-1:0]           pwm_q, pwm_d;
  logic                    load_q;
  logic [NUM_VOICES-1:0]   ack_c;
  logic                    tick_c;
  logic                    last_c;
  logic signed [DW-1:0]    sample_c;
  logic signed [DW-1:0]    sat_c;

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sample_tick (tick_c)
  );

  assign last_c   = (idx_q == IW'(NUM_VOICES-1));
  assign sample_c = voice_data[idx_q*DW +: DW];
  assign sat_c    = sat_to_dw(ACC_MAX_W'(acc_q));

`ifdef PWM_MIX_SCHED_VOLUME_EN
  logic signed [DW-1:0] scale_q, scale_d;
  logic signed [9:0]    gain_c;
  assign gain_c  = $signed({2'b00, master_vol} + 10'd1);
  assign scale_d = DW'(($signed(DW+10'(sat_c)) * $signed(DW+10'(gain_c))) >>> 8);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (tick_c) state_d = S_COLLECT;
      S_COLLECT: if (last_c) state_d = S_MIX;
`ifdef PWM_MIX_SCHED_VOLUME_EN
      S_MIX:     state_d = S_SCALE;
      S_SCALE:   state_d = S_LOAD;
`else
      S_MIX:     state_d = S_LOAD;
`endif
      S_LOAD:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Ack strobe; reset drops it in the same cycle so no sample is consumed by an aborted frame.
  always_comb begin
    ack_c = '0;
    if (state_q == S_COLLECT && voice_req[idx_q] && !reset) ack_c[idx_q] = 1'b1;
  end

  // Datapath next values
  always_comb begin
    idx_d = idx_q;
    acc_d = acc_q;
    und_d = und_q;
    pwm_d = pwm_q;
    if (clear_underrun) und_d = '0;
    case (state_q)
      S_IDLE: begin
        if (tick_c) begin
          acc_d = '0;
          idx_d = '0;
        end
      end
      S_COLLECT: begin
        if (voice_req[idx_q]) acc_d = acc_q + AW'(sample_c);
        else                  und_d[idx_q] = 1'b1;
        if (!last_c) idx_d = idx_q + IW'(1);
      end
`ifdef PWM_MIX_SCHED_VOLUME_EN
      S_SCALE: pwm_d = to_offset_bin(scale_q);
`else
      S_MIX:   pwm_d = to_offset_bin(sat_c);
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      acc_q  <= '0;
      und_q  <= '0;
      pwm_q  <= MIDSCALE;
      load_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      acc_q  <= acc_d;
      und_q  <= und_d;
      pwm_q  <= pwm_d;
      load_q <= (state_d == S_LOAD);
    end
  end

`ifdef PWM_MIX_SCHED_VOLUME_EN
  always_ff @(posedge clk) begin
    if (reset)                  scale_q <= '0;
    else if (state_q == S_MIX)  scale_q <= scale_d;
  end
`endif

  assign voice_ack   = ack_c;
  assign pwm_reg     = pwm_q;
  assign pwm_load    = load_q;
  assign sample_tick = tick_c;
  assign underrun    = und_q;

endmodule

// File: tb/tb_pwm_mix_sched.sv
// Scoreboard bench for pwm_mix_sched: frames, saturation, underrun, mid-frame reset, enable hold.
module tb_pwm_mix_sched;

  localparam int unsigned NV  = 4;
  localparam int unsigned DIV = 64;
`ifdef PWM_MIX_SCHED_VOLUME_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            clear_underrun;
  logic [NV-1:0]   voice_req;
  logic [NV*16-1:0] voice_data;
  logic [NV-1:0]   voice_ack;
  logic [NV-1:0]   underrun;
  logic [15:0]     pwm_reg;
  logic            pwm_load;
  logic            sample_tick;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] sb_q[$];
  logic [15:0] last_pwm;

  always #5 clk = ~clk;

  pwm_mix_sched #(.NUM_VOICES(NV), .SAMPLE_DIV(DIV)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .voice_req      (voice_req),
    .voice_data     (voice_data),
    .voice_ack      (voice_ack),
    .clear_underrun (clear_underrun),
`ifdef PWM_MIX_SCHED_VOLUME_EN
    .master_vol     (8'hFF),
`endif
    .pwm_reg        (pwm_reg),
    .pwm_load       (pwm_load),
    .sample_tick    (sample_tick),
    .underrun       (underrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame's voice pattern, pushes the modelled duty word and checks the frame.
  task automatic run_frame(input string nm, input logic [NV-1:0] req, input logic [NV*16-1:0] data,
                           input int clr_idx, input bit dis_en, input logic [NV-1:0] exp_und);
    int          s;
    logic [15:0] e;
    logic [15:0] want;
    logic [NV-1:0] ea;
    bit          found;
    voice_req  = req;
    voice_data = data;
    s = 0;
    for (int i = 0; i < NV; i++)
      if (req[i]) s += int'($signed(data[i*16 +: 16]));
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    e = 16'(s + 32768);
    sb_q.push_back(e);
    found = 1'b0;
    for (int c = 0; c < 3*DIV; c++) begin
      step();
      if (sample_tick) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL %s tick: no sample_tick within %0d cycles", nm, 3*DIV);
      void'(sb_q.pop_front());
      return;
    end
    if (dis_en) enable = 1'b0;
    for (int k = 0; k < NV; k++) begin
      step();
      clear_underrun = (k == clr_idx);
      ea = '0;
      if (req[k]) ea[k] = 1'b1;
      n_cmp++;
      if (voice_ack !== ea) begin
        n_err++;
        $display("FAIL %s ack[T+%0d]: got %b want %b", nm, k+1, voice_ack, ea);
      end
    end
    for (int x = 0; x < 1 + EXTRA; x++) begin
      step();
      clear_underrun = 1'b0;
      n_cmp++;
      if (pwm_load !== 1'b0) begin
        n_err++;
        $display("FAIL %s early_load: got %b want 0", nm, pwm_load);
      end
    end
    step();
    n_cmp++;
    if (pwm_load !== 1'b1) begin
      n_err++;
      $display("FAIL %s load_strobe: got %b want 1", nm, pwm_load);
    end
    want = sb_q.pop_front();
    last_pwm = want;
    n_cmp++;
    if (pwm_reg !== want) begin
      n_err++;
      $display("FAIL %s pwm_reg: got %h want %h", nm, pwm_reg, want);
    end
    n_cmp++;
    if (underrun !== exp_und) begin
      n_err++;
      $display("FAIL %s underrun: got %b want %b", nm, underrun, exp_und);
    end
    step();
    n_cmp++;
    if (pwm_load !== 1'b0) begin
      n_err++;
      $display("FAIL %s load_width: got %b want 0", nm, pwm_load);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++;
    if (pwm_reg !== 16'h8000) begin n_err++; $display("FAIL rst pwm_reg: got %h want 8000", pwm_reg); end
    n_cmp++;
    if (underrun !== 4'b0000) begin n_err++; $display("FAIL rst underrun: got %b want 0000", underrun); end
    n_cmp++;
    if (voice_ack !== 4'b0000) begin n_err++; $display("FAIL rst ack: got %b want 0000", voice_ack); end
    n_cmp++;
    if (pwm_load !== 1'b0) begin n_err++; $display("FAIL rst pwm_load: got %b want 0", pwm_load); end
    n_cmp++;
    if (sample_tick !== 1'b0) begin n_err++; $display("FAIL rst tick: got %b want 0", sample_tick); end
    reset = 1'b0;
  endtask

  task automatic test_mix();
    run_frame("mix_1000", 4'b1111, {4{16'h1000}}, -1, 1'b0, 4'b0000);
    run_frame("mix_mixed", 4'b1111, {16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF}, -1, 1'b0, 4'b0000);
  endtask

  task automatic test_saturate();
    run_frame("sat_pos", 4'b1111, {4{16'h7000}}, -1, 1'b0, 4'b0000);
    run_frame("sat_neg", 4'b1111, {4{16'h9000}}, -1, 1'b0, 4'b0000);
  endtask

  task automatic test_underrun();
    run_frame("und_miss2", 4'b1011, {4{16'h1000}}, -1, 1'b0, 4'b0100);
    for (int i = 0; i < 10; i++) step();
    n_cmp++;
    if (underrun !== 4'b0100) begin n_err++; $display("FAIL und_sticky: got %b want 0100", underrun); end
    clear_underrun = 1'b1;
    step();
    clear_underrun = 1'b0;
    n_cmp++;
    if (underrun !== 4'b0000) begin n_err++; $display("FAIL und_clear: got %b want 0000", underrun); end
    run_frame("und_lanes", 4'b1011, {16'h0800, 16'h0400, 16'h0200, 16'h0100}, -1, 1'b0, 4'b0100);
    run_frame("und_setwins", 4'b1011, {4{16'h1000}}, 2, 1'b0, 4'b0100);
  endtask

  task automatic test_reset_mid();
    bit found;
    bit bad_load;
    int n;
    voice_req  = 4'b1111;
    voice_data = {4{16'h1000}};
    found = 1'b0;
    for (int c = 0; c < 3*DIV; c++) begin
      step();
      if (sample_tick) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL rmid tick: no sample_tick within %0d cycles", 3*DIV); return; end
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (voice_ack !== 4'b0000) begin n_err++; $display("FAIL rmid ack: got %b want 0000", voice_ack); end
    n_cmp++;
    if (pwm_reg !== 16'h8000) begin n_err++; $display("FAIL rmid pwm_reg: got %h want 8000", pwm_reg); end
    n_cmp++;
    if (underrun !== 4'b0000) begin n_err++; $display("FAIL rmid underrun: got %b want 0000", underrun); end
    bad_load = 1'b0;
    n = 0;
    for (int c = 1; c <= 3*DIV; c++) begin
      step();
      if (pwm_load) bad_load = 1'b1;
      if (sample_tick) begin n = c; break; end
    end
    n_cmp++;
    if (bad_load !== 1'b0) begin n_err++; $display("FAIL rmid partial_load: got %b want 0", bad_load); end
    n_cmp++;
    if (n != DIV-1) begin n_err++; $display("FAIL rmid tick_delay: got %0d want %0d", n, DIV-1); end
    for (int i = 0; i < NV + 3 + EXTRA; i++) step();
    last_pwm = 16'hC000;
  endtask

  task automatic test_enable();
    bit saw_tick;
    bit saw_ack;
    bit pwm_moved;
    int n;
    run_frame("en_drop", 4'b1111, {4{16'h0800}}, -1, 1'b1, 4'b0000);
    saw_tick = 1'b0;
    saw_ack = 1'b0;
    pwm_moved = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (sample_tick) saw_tick = 1'b1;
      if (voice_ack !== 4'b0000) saw_ack = 1'b1;
      if (pwm_reg !== last_pwm) pwm_moved = 1'b1;
    end
    n_cmp++;
    if (saw_tick !== 1'b0) begin n_err++; $display("FAIL en_hold tick: got %b want 0", saw_tick); end
    n_cmp++;
    if (saw_ack !== 1'b0) begin n_err++; $display("FAIL en_hold ack: got %b want 0", saw_ack); end
    n_cmp++;
    if (pwm_moved !== 1'b0) begin n_err++; $display("FAIL en_hold pwm_reg: got %h want %h", pwm_reg, last_pwm); end
    enable = 1'b1;
    n = 0;
    for (int c = 1; c <= 3*DIV; c++) begin
      step();
      if (sample_tick) begin n = c; break; end
    end
    n_cmp++;
    if (n != DIV) begin n_err++; $display("FAIL en_resume tick_delay: got %0d want %0d", n, DIV); end
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b1;
    clear_underrun = 1'b0;
    voice_req      = '0;
    voice_data     = '0;
    last_pwm       = 16'h8000;
    test_reset();
    test_mix();
    test_saturate();
    test_underrun();
    test_reset_mid();
    test_enable();
    n_cmp++;
    if (sb_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
